// File: rtl/xbar_dist_pkg.sv
// Shared constants, helpers and types for the distribution crossbar.
package xbar_dist_pkg;

    localparam int unsigned DEF_DATA_TYPE   = 16;
    localparam int unsigned DEF_NUM_PES     = 32;
    localparam int unsigned DEF_INPUT_BW    = 32;
    localparam int unsigned DEF_SEL_W       = 5;
    localparam int unsigned DEF_PIPE_STAGES = 2;

    // Minimum select width able to address n input words (never below 1).
    function automatic int unsigned sel_width(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << w) < n) w = w + 1;
        end
        return w;
    endfunction

    typedef enum logic {
        CFG_EMPTY,
        CFG_PENDING
    } cfg_state_t;

    // Pipeline stage record at the default geometry; the top derives an
    // equivalent record from its own parameters.
    typedef struct packed {
        logic                                   valid;
        logic [DEF_NUM_PES-1:0]                 mask;
        logic [DEF_NUM_PES*DEF_DATA_TYPE-1:0]   data;
    } stage_rec_t;

endpackage

// File: rtl/xbar_dist_pipe_if.sv
// Handshake and bus bundle for xbar_dist_pipe; slave is the crossbar side.
interface xbar_dist_pipe_if
    import xbar_dist_pkg::*;
#(
    parameter int unsigned DATA_TYPE = DEF_DATA_TYPE,
    parameter int unsigned NUM_PES   = DEF_NUM_PES,
    parameter int unsigned INPUT_BW  = DEF_INPUT_BW,
    parameter int unsigned SEL_W     = DEF_SEL_W
);

    logic                          i_cfg_valid;
    logic [SEL_W*NUM_PES-1:0]      i_cfg_mux_bus;
    logic [NUM_PES-1:0]            i_cfg_en_mask;
    logic                          o_cfg_ready;
    logic                          i_commit;
    logic                          o_cfg_pending;

    logic                          i_data_valid;
    logic [INPUT_BW*DATA_TYPE-1:0] i_data_bus;
    logic                          o_data_ready;

    logic                          o_dist_valid;
    logic [NUM_PES*DATA_TYPE-1:0]  o_dist_bus;
    logic [NUM_PES-1:0]            o_dist_en;
    logic                          i_dist_ready;

    modport master (
        output i_cfg_valid, i_cfg_mux_bus, i_cfg_en_mask, i_commit,
        output i_data_valid, i_data_bus, i_dist_ready,
        input  o_cfg_ready, o_cfg_pending, o_data_ready,
        input  o_dist_valid, o_dist_bus, o_dist_en
    );

    modport slave (
        input  i_cfg_valid, i_cfg_mux_bus, i_cfg_en_mask, i_commit,
        input  i_data_valid, i_data_bus, i_dist_ready,
        output o_cfg_ready, o_cfg_pending, o_data_ready,
        output o_dist_valid, o_dist_bus, o_dist_en
    );

endinterface

// File: rtl/xbar_dist_lane.sv
// One crossbar output lane: pick a word by select, zero when masked or out of range.
module xbar_dist_lane
    import xbar_dist_pkg::*;
#(
    parameter int unsigned DATA_TYPE = DEF_DATA_TYPE,
    parameter int unsigned INPUT_BW  = DEF_INPUT_BW,
    parameter int unsigned SEL_W     = DEF_SEL_W
) (
    input  logic [INPUT_BW*DATA_TYPE-1:0] words,
    input  logic [SEL_W-1:0]              sel,
    input  logic                          en,
    output logic [DATA_TYPE-1:0]          word
);

    // A select matching no input index leaves the lane at zero.
    always_comb begin
        word = '0;
        for (int unsigned j = 0; j < INPUT_BW; j++) begin
            if (en && (32'(sel) == j)) begin
                word = words[j*DATA_TYPE +: DATA_TYPE];
            end
        end
    end

endmodule

// File: rtl/xbar_dist_pipe.sv
// Pipelined distribution crossbar with double-buffered routing config.
// Optional XBAR_DIST_STATS_EN adds saturating beat and stall counters.
module xbar_dist_pipe
    import xbar_dist_pkg::*;
#(
    parameter int unsigned DATA_TYPE   = DEF_DATA_TYPE,
    parameter int unsigned NUM_PES     = DEF_NUM_PES,
    parameter int unsigned INPUT_BW    = DEF_INPUT_BW,
    parameter int unsigned SEL_W       = DEF_SEL_W,
    parameter int unsigned PIPE_STAGES = DEF_PIPE_STAGES
) (
    input  logic            clk,
    input  logic            rst,
    xbar_dist_pipe_if.slave xif
`ifdef XBAR_DIST_STATS_EN
    ,
    output logic [31:0]     o_beat_cnt,
    output logic [31:0]     o_stall_cnt
`endif
);

    localparam int unsigned LAST = PIPE_STAGES - 1;

    if (SEL_W < sel_width(INPUT_BW)) begin : g_bad_sel_w
        $error("SEL_W too narrow for INPUT_BW");
    end
    if (PIPE_STAGES < 1) begin : g_bad_depth
        $error("PIPE_STAGES must be at least 1");
    end

    typedef struct packed {
        logic                         valid;
        logic [NUM_PES-1:0]           mask;
        logic [NUM_PES*DATA_TYPE-1:0] data;
    } pipe_rec_t;

    cfg_state_t               cfg_state, cfg_state_nxt;
    logic [SEL_W*NUM_PES-1:0] shadow_sel, active_sel;
    logic [NUM_PES-1:0]       shadow_mask, active_mask;
    logic                     cfg_ready, cfg_load, cfg_commit;

    always_comb begin
        cfg_state_nxt = cfg_state;
        cfg_ready     = (cfg_state == CFG_EMPTY) || xif.i_commit;
        cfg_load      = xif.i_cfg_valid && cfg_ready;
        cfg_commit    = xif.i_commit && (cfg_state == CFG_PENDING);
        if (cfg_load) begin
            cfg_state_nxt = CFG_PENDING;
        end else if (cfg_commit) begin
            cfg_state_nxt = CFG_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_state   <= CFG_EMPTY;
            shadow_sel  <= '0;
            shadow_mask <= '0;
            active_sel  <= '0;
            active_mask <= '0;
        end else begin
            cfg_state <= cfg_state_nxt;
            if (cfg_commit) begin
                active_sel  <= shadow_sel;
                active_mask <= shadow_mask;
            end
            if (cfg_load) begin
                shadow_sel  <= xif.i_cfg_mux_bus;
                shadow_mask <= xif.i_cfg_en_mask;
            end
        end
    end

    assign xif.o_cfg_ready   = cfg_ready;
    assign xif.o_cfg_pending = (cfg_state == CFG_PENDING);

    logic [NUM_PES*DATA_TYPE-1:0] routed;

    for (genvar p = 0; p < NUM_PES; p++) begin : g_lane
        xbar_dist_lane #(
            .DATA_TYPE (DATA_TYPE),
            .INPUT_BW  (INPUT_BW),
            .SEL_W     (SEL_W)
        ) u_lane (
            .words (xif.i_data_bus),
            .sel   (active_sel[p*SEL_W +: SEL_W]),
            .en    (active_mask[p]),
            .word  (routed[p*DATA_TYPE +: DATA_TYPE])
        );
    end

    pipe_rec_t                stage_q [PIPE_STAGES];
    pipe_rec_t                stage_d [PIPE_STAGES];
    logic [PIPE_STAGES-1:0]   stage_load;

    // The ready chain is flattened: stage k may load whenever the downstream
    // is ready or any stage from k onward holds a bubble.
    always_comb begin
        stage_load = '0;
        for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
            stage_load[k] = xif.i_dist_ready;
            for (int unsigned j = k; j < PIPE_STAGES; j++) begin
                if (!stage_q[j].valid) stage_load[k] = 1'b1;
            end
        end
    end

    always_comb begin
        stage_d[0].valid = xif.i_data_valid;
        stage_d[0].mask  = active_mask;
        stage_d[0].data  = routed;
        for (int unsigned k = 1; k < PIPE_STAGES; k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
            if (rst) begin
                stage_q[k] <= '0;
            end else if (stage_load[k]) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign xif.o_data_ready = stage_load[0];
    assign xif.o_dist_valid = stage_q[LAST].valid;
    assign xif.o_dist_bus   = stage_q[LAST].data;
    assign xif.o_dist_en    = stage_q[LAST].mask;

`ifdef XBAR_DIST_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_beat_cnt  <= '0;
            o_stall_cnt <= '0;
        end else begin
            if (xif.i_data_valid && stage_load[0] && (o_beat_cnt != '1)) begin
                o_beat_cnt <= o_beat_cnt + 32'd1;
            end
            if (stage_q[LAST].valid && !xif.i_dist_ready && (o_stall_cnt != '1)) begin
                o_stall_cnt <= o_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_xbar_dist_pipe.sv
// Directed self-checking bench for xbar_dist_pipe (default geometry plus a 24-input variant).
module tb_xbar_dist_pipe;
    import xbar_dist_pkg::*;

    localparam int unsigned DW = 16, NP = 32, IBW = 32, SW = 5, PS = 2, IBW_B = 24;
    localparam int unsigned MAP_IDENT = 0, MAP_REV = 1, MAP_CONST = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    xbar_dist_pipe_if #(.DATA_TYPE(DW), .NUM_PES(NP), .INPUT_BW(IBW),   .SEL_W(SW)) ifa ();
    xbar_dist_pipe_if #(.DATA_TYPE(DW), .NUM_PES(NP), .INPUT_BW(IBW_B), .SEL_W(SW)) ifb ();

`ifdef XBAR_DIST_STATS_EN
    logic [31:0] beat_cnt_a, stall_cnt_a, beat_cnt_b, stall_cnt_b;
`endif

    xbar_dist_pipe #(
        .DATA_TYPE(DW), .NUM_PES(NP), .INPUT_BW(IBW), .SEL_W(SW), .PIPE_STAGES(PS)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .xif (ifa.slave)
`ifdef XBAR_DIST_STATS_EN
        ,
        .o_beat_cnt  (beat_cnt_a),
        .o_stall_cnt (stall_cnt_a)
`endif
    );

    xbar_dist_pipe #(
        .DATA_TYPE(DW), .NUM_PES(NP), .INPUT_BW(IBW_B), .SEL_W(SW), .PIPE_STAGES(PS)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .xif (ifb.slave)
`ifdef XBAR_DIST_STATS_EN
        ,
        .o_beat_cnt  (beat_cnt_b),
        .o_stall_cnt (stall_cnt_b)
`endif
    );

    typedef struct packed {
        logic [NP*DW-1:0] bus;
        logic [NP-1:0]    en;
    } obs_t;
    obs_t outq[$];

    always @(negedge clk) begin
        if (!rst && ifa.o_dist_valid && ifa.i_dist_ready) outq.push_back({ifa.o_dist_bus, ifa.o_dist_en});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [IBW*DW-1:0] seq_words(input int unsigned base);
        logic [IBW*DW-1:0] w;
        w = '0;
        for (int unsigned j = 0; j < IBW; j++) w[j*DW +: DW] = DW'(base + j);
        return w;
    endfunction

    function automatic logic [SW*NP-1:0] sel_map(input int unsigned mode, input int unsigned c);
        logic [SW*NP-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NP; i++) begin
            if (mode == MAP_IDENT)    m[i*SW +: SW] = SW'(i);
            else if (mode == MAP_REV) m[i*SW +: SW] = SW'(NP - 1 - i);
            else                      m[i*SW +: SW] = SW'(c);
        end
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [SW*NP-1:0] sel, input logic [NP-1:0] mask);
        ifa.i_cfg_mux_bus = sel;
        ifa.i_cfg_en_mask = mask;
        ifa.i_cfg_valid   = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (ifa.o_cfg_ready) begin
                tick();
                ifa.i_cfg_valid = 1'b0;
                return;
            end
            tick();
        end
        ifa.i_cfg_valid = 1'b0;
        checks++; errors++;
        $display("FAIL cfg_load_timeout: o_cfg_ready got 0 expected 1");
    endtask

    task automatic commit();
        ifa.i_commit = 1'b1;
        tick();
        ifa.i_commit = 1'b0;
    endtask

    task automatic send_beat(input logic [IBW*DW-1:0] data);
        logic acc;
        ifa.i_data_bus   = data;
        ifa.i_data_valid = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            acc = ifa.o_data_ready;
            tick();
            if (acc) begin
                ifa.i_data_valid = 1'b0;
                return;
            end
        end
        ifa.i_data_valid = 1'b0;
        checks++; errors++;
        $display("FAIL send_timeout: o_data_ready got 0 expected 1");
    endtask

    task automatic wait_valid(input string tag);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (ifa.o_dist_valid) return;
        end
        checks++; errors++;
        $display("FAIL %s_timeout: o_dist_valid got 0 expected 1", tag);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checks++; if (ifa.o_dist_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", ifa.o_dist_valid); end
        checks++; if (ifa.o_cfg_pending !== 1'b0) begin errors++; $display("FAIL rst_pending: got %b expected 0", ifa.o_cfg_pending); end
        checks++; if (ifa.o_cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_cfg_ready: got %b expected 1", ifa.o_cfg_ready); end
        checks++; if (ifa.o_data_ready !== 1'b1) begin errors++; $display("FAIL rst_data_ready: got %b expected 1", ifa.o_data_ready); end
        checks++; if (ifa.o_dist_en !== '0) begin errors++; $display("FAIL rst_en: got %h expected 0", ifa.o_dist_en); end
        checks++; if (ifa.o_dist_bus !== '0) begin errors++; $display("FAIL rst_bus: got %h expected 0", ifa.o_dist_bus); end
        checks++; if (ifb.o_dist_valid !== 1'b0) begin errors++; $display("FAIL rst_b_valid: got %b expected 0", ifb.o_dist_valid); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_identity();
        logic [NP*DW-1:0] exp;
        load_cfg(sel_map(MAP_IDENT, 0), '1);
        commit();
        send_beat(seq_words(1));
        @(negedge clk);
        checks++; if (ifa.o_dist_valid !== 1'b0) begin errors++; $display("FAIL ident_latency_early: valid got %b expected 0", ifa.o_dist_valid); end
        @(negedge clk);
        checks++; if (ifa.o_dist_valid !== 1'b1) begin errors++; $display("FAIL ident_latency: valid got %b expected 1", ifa.o_dist_valid); end
        exp = '0;
        for (int unsigned i = 0; i < NP; i++) exp[i*DW +: DW] = DW'(i + 1);
        checks++; if (ifa.o_dist_bus !== exp) begin errors++; $display("FAIL ident_bus: got %h expected %h", ifa.o_dist_bus, exp); end
        checks++; if (ifa.o_dist_en !== '1) begin errors++; $display("FAIL ident_en: got %h expected all ones", ifa.o_dist_en); end
        repeat (3) tick();
    endtask

    task automatic test_broadcast_mask();
        logic [NP*DW-1:0] exp;
        load_cfg(sel_map(MAP_CONST, 3), 32'h0000_FFFF);
        commit();
        send_beat(seq_words(16'h0100));
        wait_valid("bcast");
        exp = '0;
        for (int unsigned i = 0; i < 16; i++) exp[i*DW +: DW] = 16'h0103;
        checks++; if (ifa.o_dist_bus !== exp) begin errors++; $display("FAIL bcast_bus: got %h expected %h", ifa.o_dist_bus, exp); end
        checks++; if (ifa.o_dist_en !== 32'h0000_FFFF) begin errors++; $display("FAIL bcast_en: got %h expected 0000ffff", ifa.o_dist_en); end
        repeat (3) tick();
    endtask

    task automatic test_out_of_range();
        logic [SW*NP-1:0]     sel;
        logic [IBW_B*DW-1:0]  data;
        logic [NP*DW-1:0]     exp;
        bit                   seen;
        sel = '0;
        sel[0*SW +: SW] = 5'd30;
        sel[1*SW +: SW] = 5'd23;
        sel[2*SW +: SW] = 5'd24;
        sel[3*SW +: SW] = 5'd5;
        for (int unsigned j = 0; j < IBW_B; j++) data[j*DW +: DW] = DW'(16'h0200 + j);
        ifb.i_cfg_mux_bus = sel;
        ifb.i_cfg_en_mask = '1;
        ifb.i_cfg_valid   = 1'b1;
        tick();
        ifb.i_cfg_valid = 1'b0;
        ifb.i_commit    = 1'b1;
        tick();
        ifb.i_commit     = 1'b0;
        ifb.i_data_bus   = data;
        ifb.i_data_valid = 1'b1;
        tick();
        ifb.i_data_valid = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            seen = ifb.o_dist_valid;
        end
        checks++; if (!seen) begin errors++; $display("FAIL oor_valid: got 0 expected 1"); end
        exp = '0;
        exp[1*DW +: DW] = 16'h0217;
        exp[3*DW +: DW] = 16'h0205;
        for (int unsigned i = 4; i < NP; i++) exp[i*DW +: DW] = 16'h0200;
        checks++; if (ifb.o_dist_bus[0 +: DW] !== 16'h0000) begin errors++; $display("FAIL oor_lane0_sel30: got %h expected 0000", ifb.o_dist_bus[0 +: DW]); end
        checks++; if (ifb.o_dist_bus !== exp) begin errors++; $display("FAIL oor_bus: got %h expected %h", ifb.o_dist_bus, exp); end
        checks++; if (ifb.o_dist_en !== '1) begin errors++; $display("FAIL oor_en: got %h expected all ones", ifb.o_dist_en); end
        repeat (3) tick();
    endtask

    task automatic test_midstream_commit();
        logic [NP*DW-1:0] exp;
        load_cfg(sel_map(MAP_IDENT, 0), '1);
        commit();
        load_cfg(sel_map(MAP_REV, 0), '1);
        outq.delete();
        ifa.i_data_valid = 1'b1;
        for (int unsigned b = 0; b < 8; b++) begin
            ifa.i_data_bus = seq_words(b * 64);
            ifa.i_commit   = (b == 4);
            @(negedge clk);
            checks++; if (ifa.o_data_ready !== 1'b1) begin errors++; $display("FAIL mid_accept%0d: ready got %b expected 1", b, ifa.o_data_ready); end
            tick();
        end
        ifa.i_data_valid = 1'b0;
        ifa.i_commit     = 1'b0;
        repeat (PS + 3) tick();
        checks++; if (outq.size() != 8) begin errors++; $display("FAIL mid_count: got %0d expected 8", outq.size()); end
        for (int unsigned b = 0; b < 8 && b < outq.size(); b++) begin
            exp = '0;
            for (int unsigned i = 0; i < NP; i++) exp[i*DW +: DW] = (b <= 4) ? DW'(b*64 + i) : DW'(b*64 + NP - 1 - i);
            checks++; if (outq[b].bus !== exp) begin errors++; $display("FAIL mid_beat%0d: got %h expected %h", b, outq[b].bus, exp); end
        end
    endtask

    task automatic test_stall_hold();
        logic [NP*DW-1:0] exp, snap;
        outq.delete();
        ifa.i_dist_ready = 1'b0;
        send_beat(seq_words(16'h0400));
        send_beat(seq_words(16'h0500));
        ifa.i_data_bus   = seq_words(16'h0600);
        ifa.i_data_valid = 1'b1;
        @(negedge clk);
        checks++; if (ifa.o_data_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", ifa.o_data_ready); end
        exp = '0;
        for (int unsigned i = 0; i < NP; i++) exp[i*DW +: DW] = DW'(16'h0400 + NP - 1 - i);
        checks++; if (ifa.o_dist_valid !== 1'b1 || ifa.o_dist_bus !== exp) begin errors++; $display("FAIL stall_head: valid %b bus %h expected 1 %h", ifa.o_dist_valid, ifa.o_dist_bus, exp); end
        snap = ifa.o_dist_bus;
        for (int c = 0; c < 4; c++) begin
            tick();
            @(negedge clk);
            checks++;
            if (ifa.o_dist_valid !== 1'b1 || ifa.o_dist_bus !== snap || ifa.o_dist_en !== '1 || ifa.o_data_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: valid %b ready %b bus %h expected 1 0 %h", c, ifa.o_dist_valid, ifa.o_data_ready, ifa.o_dist_bus, snap);
            end
        end
        tick();
        ifa.i_dist_ready = 1'b1;
        @(negedge clk);
        checks++; if (ifa.o_data_ready !== 1'b1) begin errors++; $display("FAIL unstall_ready: got %b expected 1", ifa.o_data_ready); end
        tick();
        ifa.i_data_valid = 1'b0;
        repeat (4) tick();
        checks++; if (outq.size() != 3) begin errors++; $display("FAIL stall_count: got %0d expected 3", outq.size()); end
        for (int unsigned b = 0; b < 3 && b < outq.size(); b++) begin
            exp = '0;
            for (int unsigned i = 0; i < NP; i++) exp[i*DW +: DW] = DW'(16'h0400 + b*256 + NP - 1 - i);
            checks++; if (outq[b].bus !== exp) begin errors++; $display("FAIL stall_order%0d: got %h expected %h", b, outq[b].bus, exp); end
        end
    endtask

    task automatic test_backpressure();
        logic [NP*DW-1:0] exp;
        bit done;
        done = 1'b0;
        outq.delete();
        fork
            begin
                for (int unsigned b = 0; b < 200; b++) send_beat(seq_words(b * 32));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    ifa.i_dist_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        ifa.i_dist_ready = 1'b1;
        repeat (6) tick();
        checks++; if (outq.size() != 200) begin errors++; $display("FAIL bp_count: got %0d expected 200", outq.size()); end
        for (int unsigned b = 0; b < 200 && b < outq.size(); b++) begin
            exp = '0;
            for (int unsigned i = 0; i < NP; i++) exp[i*DW +: DW] = DW'(b*32 + NP - 1 - i);
            checks++;
            if (outq[b].bus !== exp || outq[b].en !== '1) begin
                errors++;
                $display("FAIL bp_beat%0d: got %h expected %h", b, outq[b].bus, exp);
            end
        end
    endtask

    task automatic test_cfg_handshake();
        logic [NP*DW-1:0] exp;
        load_cfg(sel_map(MAP_CONST, 1), '1);
        ifa.i_cfg_mux_bus = sel_map(MAP_CONST, 2);
        ifa.i_cfg_valid   = 1'b1;
        @(negedge clk);
        checks++; if (ifa.o_cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_second_load_ready: got %b expected 0", ifa.o_cfg_ready); end
        checks++; if (ifa.o_cfg_pending !== 1'b1) begin errors++; $display("FAIL cfg_pending_set: got %b expected 1", ifa.o_cfg_pending); end
        tick();
        ifa.i_commit = 1'b1;
        @(negedge clk);
        checks++; if (ifa.o_cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_ready_on_commit: got %b expected 1", ifa.o_cfg_ready); end
        tick();
        ifa.i_commit    = 1'b0;
        ifa.i_cfg_valid = 1'b0;
        @(negedge clk);
        checks++; if (ifa.o_cfg_pending !== 1'b1) begin errors++; $display("FAIL cfg_commit_load_pending: got %b expected 1", ifa.o_cfg_pending); end
        tick();
        send_beat(seq_words(16'h0300));
        wait_valid("cfg_a");
        exp = '0;
        for (int unsigned i = 0; i < NP; i++) exp[i*DW +: DW] = 16'h0301;
        checks++; if (ifa.o_dist_bus !== exp) begin errors++; $display("FAIL cfg_old_shadow_active: got %h expected %h", ifa.o_dist_bus, exp); end
        commit();
        @(negedge clk);
        checks++; if (ifa.o_cfg_pending !== 1'b0) begin errors++; $display("FAIL cfg_pending_clear: got %b expected 0", ifa.o_cfg_pending); end
        tick();
        send_beat(seq_words(16'h0300));
        wait_valid("cfg_b");
        for (int unsigned i = 0; i < NP; i++) exp[i*DW +: DW] = 16'h0302;
        checks++; if (ifa.o_dist_bus !== exp) begin errors++; $display("FAIL cfg_new_active: got %h expected %h", ifa.o_dist_bus, exp); end
        commit();
        @(negedge clk);
        checks++; if (ifa.o_cfg_pending !== 1'b0) begin errors++; $display("FAIL cfg_empty_commit_pending: got %b expected 0", ifa.o_cfg_pending); end
        tick();
        send_beat(seq_words(16'h0300));
        wait_valid("cfg_c");
        checks++; if (ifa.o_dist_bus !== exp) begin errors++; $display("FAIL cfg_empty_commit_ignored: got %h expected %h", ifa.o_dist_bus, exp); end
        repeat (3) tick();
    endtask

    task automatic test_reset_midstream();
        ifa.i_dist_ready = 1'b0;
        send_beat(seq_words(16'h0700));
        send_beat(seq_words(16'h0710));
        load_cfg(sel_map(MAP_IDENT, 0), '1);
        rst = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (ifa.o_dist_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", ifa.o_dist_valid); end
        checks++; if (ifa.o_cfg_pending !== 1'b0) begin errors++; $display("FAIL rstmid_pending: got %b expected 0", ifa.o_cfg_pending); end
        checks++; if (ifa.o_dist_en !== '0) begin errors++; $display("FAIL rstmid_en: got %h expected 0", ifa.o_dist_en); end
        tick();
        rst = 1'b0;
        ifa.i_dist_ready = 1'b1;
        outq.delete();
        send_beat(seq_words(16'h0720));
        wait_valid("rstmid");
        checks++; if (ifa.o_dist_bus !== '0 || ifa.o_dist_en !== '0) begin errors++; $display("FAIL rstmid_active_cleared: bus %h en %h expected 0 0", ifa.o_dist_bus, ifa.o_dist_en); end
        repeat (4) tick();
        checks++; if (outq.size() != 1) begin errors++; $display("FAIL rstmid_no_stale: got %0d beats expected 1", outq.size()); end
    endtask

    initial begin
        ifa.i_cfg_valid = 1'b0; ifa.i_cfg_mux_bus = '0; ifa.i_cfg_en_mask = '0; ifa.i_commit = 1'b0;
        ifa.i_data_valid = 1'b0; ifa.i_data_bus = '0; ifa.i_dist_ready = 1'b1;
        ifb.i_cfg_valid = 1'b0; ifb.i_cfg_mux_bus = '0; ifb.i_cfg_en_mask = '0; ifb.i_commit = 1'b0;
        ifb.i_data_valid = 1'b0; ifb.i_data_bus = '0; ifb.i_dist_ready = 1'b1;
        test_reset();
        test_identity();
        test_broadcast_mask();
        test_out_of_range();
        test_midstream_commit();
        test_stall_hold();
        test_backpressure();
        test_cfg_handshake();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
